// File: rtl/neopixel_pkg.sv
// neopixel_pkg
//   Shared definitions for the NeoPixel transmitter: the controller state
//   encoding, the pixel word width and the default bit/latch timing (in clock
//   cycles at 50 MHz).
package neopixel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    LATCH = 2'd3
  } tx_state_t;

  localparam int PIXEL_WIDTH = 24;

  localparam int DEF_T0H    = 20;    // 0.4 us high time for a 0 bit
  localparam int DEF_T1H    = 40;    // 0.8 us high time for a 1 bit
  localparam int DEF_TBIT   = 63;    // 1.26 us full bit period
  localparam int DEF_TLATCH = 2600;  // 52 us low time that latches the LEDs

endpackage

// File: rtl/neopixel_bit_timer.sv
// bit_timer
//   Down-counting phase timer shared by every phase of the transmitter.
//   A phase of N cycles is started by loading N; done is high during the last
//   cycle of the phase (count == 1), which is when the controller decides the
//   next phase and reloads.
//   Ports:
//     clock    - rising-edge clock
//     reset_L  - asynchronous active-low reset, count forced to 0
//     load     - load load_val (has priority over en)
//     en       - count down by one (holds at 0)
//     load_val - phase length in cycles
//     done     - current cycle is the last of the phase
module bit_timer #(
  parameter int W = 12
) (
  input  logic         clock,
  input  logic         reset_L,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                  cnt_d = load_val;
    else if (en && cnt_q != '0) cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign done = (cnt_q == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/reg_lib.sv
// lib_reg
//   Generic enabled register from the shared register library.
//   Ports:
//     clock    - rising-edge clock
//     reset_L  - asynchronous active-low reset, clears q
//     clear    - synchronous clear (has priority over en)
//     en       - load enable
//     d        - next value
//     q        - registered value
module lib_reg #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_L,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L)   q <= '0;
    else if (clear) q <= '0;
    else if (en)    q <= d;
  end

endmodule

// File: rtl/neopixel_tx.sv
// neopixel_tx
//   Serialises 24-bit GRB pixel words onto a single NeoPixel data line, MSB
//   first. Each bit is a fixed TBIT-cycle period: high for T1H (1) or T0H (0)
//   cycles, then low for the rest. A pixel flagged last is followed by TLATCH
//   low cycles. A new pixel may be accepted in the final cycle of a non-last
//   pixel so back-to-back pixels stream with no gap.
//   Ports:
//     clock       - rising-edge clock
//     reset_L     - asynchronous active-low reset, aborts any transfer
//     pixel_data  - GRB word, G[7] in bit 23
//     pixel_last  - pixel_data is the final pixel of a frame
//     pixel_valid - pixel_data/pixel_last are valid
//     pixel_ready - a pixel is accepted this cycle when valid
//     serial_out  - NeoPixel data line (registered)
//     busy        - controller is not idle
module neopixel_tx
  import neopixel_pkg::*;
#(
  parameter int T0H    = DEF_T0H,
  parameter int T1H    = DEF_T1H,
  parameter int TBIT   = DEF_TBIT,
  parameter int TLATCH = DEF_TLATCH
) (
  input  logic                   clock,
  input  logic                   reset_L,
  input  logic [PIXEL_WIDTH-1:0] pixel_data,
  input  logic                   pixel_last,
  input  logic                   pixel_valid,
  output logic                   pixel_ready,
  output logic                   serial_out,
  output logic                   busy
);

  localparam int CW = $clog2(((TBIT > TLATCH) ? TBIT : TLATCH) + 1);

  tx_state_t              state_q, state_d;
  logic [4:0]             idx_q, idx_d;
  logic                   last_q, last_d;
  logic                   serial_q;
  logic [PIXEL_WIDTH-1:0] shreg_q, shreg_d;
  logic                   shreg_en;
  logic                   tmr_load, tmr_done;
  logic [CW-1:0]          tmr_val;
  logic                   xfer;

  function automatic logic [CW-1:0] high_len(input logic b);
    return b ? CW'(T1H) : CW'(T0H);
  endfunction

  function automatic logic [CW-1:0] low_len(input logic b);
    return b ? CW'(TBIT - T1H) : CW'(TBIT - T0H);
  endfunction

  bit_timer #(.W(CW)) u_timer (
    .clock    (clock),
    .reset_L  (reset_L),
    .load     (tmr_load),
    .en       (busy),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  lib_reg #(.W(PIXEL_WIDTH)) u_shreg (
    .clock   (clock),
    .reset_L (reset_L),
    .clear   (1'b0),
    .en      (shreg_en),
    .d       (shreg_d),
    .q       (shreg_q)
  );

  always_comb begin
    // Ready in IDLE, and in the very last cycle of a non-last pixel so the
    // next pixel's first bit follows without a gap.
    pixel_ready = (state_q == IDLE) ||
                  ((state_q == LOW) && tmr_done && (idx_q == 5'd0) && !last_q);
    xfer        = pixel_valid && pixel_ready;

    state_d  = state_q;
    idx_d    = idx_q;
    last_d   = last_q;
    shreg_d  = shreg_q << 1;
    shreg_en = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;

    if (xfer) begin
      shreg_d  = pixel_data;
      shreg_en = 1'b1;
      last_d   = pixel_last;
      idx_d    = 5'd23;
      state_d  = HIGH;
      tmr_load = 1'b1;
      tmr_val  = high_len(pixel_data[PIXEL_WIDTH-1]);
    end else begin
      case (state_q)
        HIGH: begin
          if (tmr_done) begin
            state_d  = LOW;
            tmr_load = 1'b1;
            tmr_val  = low_len(shreg_q[PIXEL_WIDTH-1]);
          end
        end
        LOW: begin
          if (tmr_done) begin
            if (idx_q != 5'd0) begin
              // Next bit is one position down; it becomes the MSB after the shift.
              shreg_en = 1'b1;
              idx_d    = idx_q - 5'd1;
              state_d  = HIGH;
              tmr_load = 1'b1;
              tmr_val  = high_len(shreg_q[PIXEL_WIDTH-2]);
            end else if (last_q) begin
              state_d  = LATCH;
              tmr_load = 1'b1;
              tmr_val  = CW'(TLATCH);
            end else begin
              state_d  = IDLE;
            end
          end
        end
        LATCH: begin
          if (tmr_done) state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= IDLE;
      idx_q    <= 5'd23;
      last_q   <= 1'b0;
      serial_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      serial_q <= (state_d == HIGH);
    end
  end

  assign serial_out = serial_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_neopixel_tx.sv
module tb_neopixel_tx;

  localparam int T0H    = 20;
  localparam int T1H    = 40;
  localparam int TBIT   = 63;
  localparam int TLATCH = 2600;

  logic        clock = 1'b0;
  logic        reset_L = 1'b0;
  logic [23:0] pixel_data = '0;
  logic        pixel_last = 1'b0;
  logic        pixel_valid = 1'b0;
  logic        pixel_ready, serial_out, busy;

  neopixel_tx dut (
    .clock       (clock),
    .reset_L     (reset_L),
    .pixel_data  (pixel_data),
    .pixel_last  (pixel_last),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .serial_out  (serial_out),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  // Reference: the expected line level for every upcoming cycle, appended a
  // whole pixel at a time when the model accepts it.
  bit wave[$];
  bit tail_open = 1'b0;
  int acc_cnt = 0;

  int hi_cnt = 0, busy_cnt = 0, rb_cnt = 0;

  function automatic bit m_ready();
    return (wave.size() == 0) || (wave.size() == 1 && tail_open);
  endfunction

  function automatic bit m_serial();
    return (wave.size() > 0) ? wave[0] : 1'b0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clock or negedge reset_L);
    if (!reset_L) begin
      wave.delete();
      tail_open = 1'b0;
    end else begin
      bit rdy;
      int h;
      rdy = m_ready();
      if (wave.size() > 0) void'(wave.pop_front());
      if (rdy && pixel_valid) begin
        for (int b = 23; b >= 0; b--) begin
          h = pixel_data[b] ? T1H : T0H;
          for (int c = 0; c < TBIT; c++) wave.push_back(c < h);
        end
        if (pixel_last)
          for (int c = 0; c < TLATCH; c++) wave.push_back(1'b0);
        tail_open = !pixel_last;
        acc_cnt++;
      end
    end
  end

  initial forever begin
    @(negedge clock);
    if (reset_L) begin
      check("serial_out", serial_out, m_serial());
      check("pixel_ready", pixel_ready, m_ready());
      check("busy", busy, (wave.size() > 0));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
    hi_cnt   += serial_out;
    busy_cnt += busy;
    rb_cnt   += (pixel_ready && busy);
  endtask

  task automatic clr();
    hi_cnt = 0; busy_cnt = 0; rb_cnt = 0;
  endtask

  // mode 0: valid low until ready; 1: valid held with the pixel; 2: random noise
  task automatic send(input logic [23:0] d, input logic l, input int mode, output int steps);
    int start;
    start = acc_cnt;
    steps = 0;
    while (acc_cnt == start && steps < 10000) begin
      if (m_ready() || mode == 1) begin
        pixel_valid = 1'b1; pixel_data = d; pixel_last = l;
      end else if (mode == 2) begin
        pixel_valid = 1'($urandom_range(0, 1));
        pixel_data  = 24'($urandom);
        pixel_last  = 1'($urandom_range(0, 1));
      end else begin
        pixel_valid = 1'b0;
      end
      step();
      steps++;
    end
    if (acc_cnt == start) check("send_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int mode);
    int guard;
    guard = 0;
    while (wave.size() > 0 && guard < 20000) begin
      if (mode == 2 && !m_ready()) begin
        pixel_valid = 1'($urandom_range(0, 1));
        pixel_data  = 24'($urandom);
        pixel_last  = 1'($urandom_range(0, 1));
      end else begin
        pixel_valid = 1'b0;
      end
      step();
      guard++;
    end
    pixel_valid = 1'b0;
    if (wave.size() > 0) check("idle_timeout", 0, 1);
  endtask

  initial begin
    int st;
    logic [23:0] d;
    logic l;

    #12;
    check("rst_serial", serial_out, 0);
    check("rst_ready", pixel_ready, 1);
    check("rst_busy", busy, 0);
    @(posedge clock); #3 reset_L = 1'b1;

    // Single pixel, last
    clr();
    send(24'hFF0000, 1'b1, 0, st);
    check("A_model_len", wave.size(), 4112);
    wait_idle(0);
    check("A_high_cycles", hi_cnt, 640);
    check("A_busy_cycles", busy_cnt, 4112);

    // Back-to-back pair with valid held
    clr();
    send(24'hAAAAAA, 1'b0, 1, st);
    send(24'h555555, 1'b1, 1, st);
    wait_idle(0);
    check("B_high_cycles", hi_cnt, 1440);
    check("B_busy_cycles", busy_cnt, 5624);
    check("B_ready_at_boundary", rb_cnt, 1);

    // Underflow
    clr();
    send(24'h000001, 1'b0, 0, st);
    wait_idle(0);
    check("U_busy_cycles", busy_cnt, 1512);
    check("U_high_cycles", hi_cnt, 500);
    check("U_ready_cycles", rb_cnt, 1);
    check("U_ready_end", pixel_ready, 1);
    check("U_busy_end", busy, 0);
    check("U_serial_end", serial_out, 0);

    // Reset in the 10th cycle of bit 5
    clr();
    send(24'hC3A5F0, 1'b1, 0, st);
    pixel_valid = 1'b0;
    repeat (18 * TBIT + 9) step();
    check("R_serial_before", serial_out, 1);
    #2 reset_L = 1'b0;
    #1;
    check("R_serial_async", serial_out, 0);
    check("R_busy_async", busy, 0);
    check("R_ready_async", pixel_ready, 1);
    @(posedge clock); #3 reset_L = 1'b1;
    clr();
    send(24'h00FF00, 1'b1, 0, st);
    check("R_accept_steps", st, 1);
    check("R_busy_after", busy, 1);
    wait_idle(0);
    check("R_high_cycles", hi_cnt, 640);
    check("R_busy_cycles", busy_cnt, 4112);

    // Random pixels with input noise while not ready
    for (int i = 0; i < 8; i++) begin
      d = 24'($urandom);
      l = (i == 7) ? 1'b1 : ($urandom_range(0, 3) == 0);
      send(d, l, 2, st);
      if ($urandom_range(0, 2) == 0)
        repeat ($urandom_range(1, 3)) begin
          pixel_valid = 1'b0;
          step();
        end
    end
    wait_idle(2);
    check("X_idle_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
